// File: rtl/sipo_collect.sv
// Serial-in/parallel-out word collector: packs WIDTH accepted bits into a word
// and presents it on a valid/ready output, double-buffered against the shift reg.
module sipo_collect #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q,   sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q,  vld_d;
  logic [CW-1:0]    cnt_q,  cnt_d;

  logic             last_bit;
  logic             acc_in;
  logic             out_take;
  logic             complete;
  logic [WIDTH-1:0] shifted;

  assign last_bit = (cnt_q == LAST);
  // Only the word-completing bit can be blocked, and only by a full, unread output reg.
  assign in_ready = !(last_bit && vld_q && !out_ready);
  assign acc_in   = in_valid && in_ready;
  assign out_take = vld_q && out_ready;
  assign complete = acc_in && last_bit && !clear;

  always_comb begin
    shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], in_bit} : {in_bit, sr_q[WIDTH-1:1]};
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (acc_in) begin
      if (last_bit) begin
        data_d = shifted;
        sr_d   = '0;
        cnt_d  = '0;
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_q + CW'(1);
      end
    end
    // A completing word overrides the take so back-to-back words see no bubble.
    if (out_take) vld_d = 1'b0;
    if (complete) vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_collect.sv
// Bench for sipo_collect: MSB-first and LSB-first instances share one input
// stream; completed words are predicted into queues and matched on each take.
module tb_sipo_collect;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, in_bit, out_ready;
  logic       in_ready_m, out_valid_m, in_ready_l, out_valid_l;
  logic [7:0] out_data_m, out_data_l;
  logic [2:0] bit_cnt_m, bit_cnt_l;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stalls;
  int prev_pop;
  bit rate_chk  = 1'b0;
  bit have_prev = 1'b0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  sipo_collect #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_m), .out_valid(out_valid_m), .out_data(out_data_m),
    .out_ready(out_ready), .bit_cnt(bit_cnt_m)
  );

  sipo_collect #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_l), .out_valid(out_valid_l), .out_data(out_data_l),
    .out_ready(out_ready), .bit_cnt(bit_cnt_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (out_valid_m === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (q_m.size() == 0) begin
          errors++;
          $display("FAIL sb_msb: got word %h, expected none", out_data_m);
        end else begin
          e = q_m.pop_front();
          if (out_data_m !== e) begin
            errors++;
            $display("FAIL sb_msb: got %h, expected %h", out_data_m, e);
          end
        end
        if (rate_chk) begin
          if (have_prev) begin
            checks++;
            if (cyc - prev_pop != 8) begin
              errors++;
              $display("FAIL word_rate: gap %0d cycles, expected 8", cyc - prev_pop);
            end
          end
          prev_pop  = cyc;
          have_prev = 1'b1;
        end
      end
      if (out_valid_l === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (q_l.size() == 0) begin
          errors++;
          $display("FAIL sb_lsb: got word %h, expected none", out_data_l);
        end else begin
          e = q_l.pop_front();
          if (out_data_l !== e) begin
            errors++;
            $display("FAIL sb_lsb: got %h, expected %h", out_data_l, e);
          end
        end
      end
    end
  endtask

  // Offers one bit and returns at posedge+1 once it has been accepted.
  task automatic send_bit(input logic b);
    int n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    while (in_ready_m !== 1'b1 && n < 100) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready_m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    q_m.push_back(w);
    q_l.push_back(rev8(w));
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid_m !== 1'b0 || out_valid_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b, expected 0/0", out_valid_m, out_valid_l);
    end
    checks++;
    if (out_data_m !== 8'h00 || out_data_l !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h/%h, expected 00/00", out_data_m, out_data_l);
    end
    checks++;
    if (bit_cnt_m !== 3'd0 || bit_cnt_l !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d, expected 0/0", bit_cnt_m, bit_cnt_l);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_bit_order();
    out_ready = 1'b1;
    stalls    = 0;
    send_word(8'hB2);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_m !== 1'b1 || out_valid_l !== 1'b1) begin
      errors++;
      $display("FAIL order_valid: got %b/%b, expected 1/1", out_valid_m, out_valid_l);
    end
    checks++;
    if (out_data_m !== 8'hB2) begin
      errors++;
      $display("FAIL order_msb: got %h, expected b2", out_data_m);
    end
    checks++;
    if (out_data_l !== 8'h4D) begin
      errors++;
      $display("FAIL order_lsb: got %h, expected 4d", out_data_l);
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL order_ready: got %0d stall cycles, expected 0", stalls);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    v = 8'h5A;
    out_ready = 1'b0;
    send_word(8'hB2);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    in_valid = 1'b1;
    in_bit   = v[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bit_cnt_m !== 3'd7 || in_ready_m !== 1'b0 || in_ready_l !== 1'b0) begin
        errors++;
        $display("FAIL stall_state: cnt=%0d ready=%b/%b, expected cnt=7 ready=0/0",
                 bit_cnt_m, in_ready_m, in_ready_l);
      end
      checks++;
      if (out_valid_m !== 1'b1 || out_data_m !== 8'hB2) begin
        errors++;
        $display("FAIL stall_hold: valid=%b data=%h, expected 1 b2", out_valid_m, out_data_m);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_m !== 1'b1) begin
      errors++;
      $display("FAIL ready_comb: got %b, expected 1", in_ready_m);
    end
    q_m.push_back(v);
    q_l.push_back(rev8(v));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_m !== 1'b1 || out_data_m !== 8'h5A || bit_cnt_m !== 3'd0) begin
      errors++;
      $display("FAIL release: valid=%b data=%h cnt=%0d, expected 1 5a 0",
               out_valid_m, out_data_m, bit_cnt_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    send_word(8'hC3);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bit_cnt_m !== 3'd3) begin
      errors++;
      $display("FAIL idle_hold: cnt=%0d, expected 3", bit_cnt_m);
    end
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bit_cnt_m !== 3'd0 || bit_cnt_l !== 3'd0) begin
      errors++;
      $display("FAIL clear_cnt: got %0d/%0d, expected 0/0", bit_cnt_m, bit_cnt_l);
    end
    checks++;
    if (out_valid_m !== 1'b1 || out_data_m !== 8'hC3) begin
      errors++;
      $display("FAIL clear_keep: valid=%b data=%h, expected 1 c3", out_valid_m, out_data_m);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(8'hFF);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_data_m !== 8'hFF || out_data_l !== 8'hFF) begin
      errors++;
      $display("FAIL clear_ff: got %h/%h, expected ff/ff", out_data_m, out_data_l);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    words     = '{8'hA5, 8'h3C, 8'hF0, 8'h81};
    out_ready = 1'b1;
    stalls    = 0;
    have_prev = 1'b0;
    rate_chk  = 1'b1;
    foreach (words[i]) send_word(words[i]);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rate_chk = 1'b0;
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL stream_ready: got %0d stall cycles, expected 0", stalls);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_bit_order();
    test_backpressure();
    test_clear();
    test_back_to_back();
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d words outstanding, expected 0/0", q_m.size(), q_l.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
